// File: rtl/hamming74_serial_tx_pkg.sv
// Shared definitions for the Hamming(7,4) serial transmitter and its decoder.
// Codeword bit i-1 holds position i; positions are p1 p2 d1 p4 d2 d3 d4.
package hamming74_serial_tx_pkg;

  localparam int unsigned CwWidth   = 7;
  localparam int unsigned DataWidth = 4;
  // Start bit + 7 code bits + stop bit.
  localparam int unsigned FrameBits = 9;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  // Parity coverage masks: parity p_k covers every position whose index has bit k set.
  localparam logic [CwWidth-1:0] P1Cover = 7'b1010101;  // positions 1,3,5,7
  localparam logic [CwWidth-1:0] P2Cover = 7'b1100110;  // positions 2,3,6,7
  localparam logic [CwWidth-1:0] P4Cover = 7'b1111000;  // positions 4,5,6,7

  // Scatter d1..d4 into positions 3,5,6,7 with parity slots left at zero.
  function automatic logic [CwWidth-1:0] place_data(input logic [DataWidth-1:0] d);
    return {d[3], d[2], d[1], 1'b0, d[0], 2'b00};
  endfunction

endpackage

// File: rtl/hamming74_encode.sv
// Combinational Hamming(7,4) encoder with optional single-bit error injection.
// Also used by the decoder's bench as a golden encoder.
module hamming74_encode
  import hamming74_serial_tx_pkg::*;
(
  input  logic [DataWidth-1:0] data_in,
  input  logic [2:0]           err_pos,
  output logic [CwWidth-1:0]   codeword
);

  logic [CwWidth-1:0] data_placed;
  logic [CwWidth-1:0] clean_cw;
  logic [CwWidth-1:0] flip_mask;

  // Fill parity slots from the coverage masks, then flip position err_pos if non-zero.
  always_comb begin
    data_placed = place_data(data_in);
    clean_cw    = data_placed;
    // Parity slots are zero in data_placed, so each XOR sees only its data bits.
    clean_cw[0] = ^(data_placed & P1Cover);
    clean_cw[1] = ^(data_placed & P2Cover);
    clean_cw[3] = ^(data_placed & P4Cover);
    flip_mask   = '0;
    if (err_pos != 3'd0) begin
      flip_mask = CwWidth'(1) << (err_pos - 3'd1);
    end
    codeword = clean_cw ^ flip_mask;
  end

endmodule

// File: rtl/hamming74_serial_tx.sv
// Hamming(7,4) serial transmitter: accepts a nibble, encodes it (with optional
// error injection) and shifts out start bit, 7 code bits LSB first, stop bit.
module hamming74_serial_tx
  import hamming74_serial_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DataWidth-1:0] data_in,
  input  logic [2:0]           err_pos,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 frame_done,
  output logic [CwWidth-1:0]   codeword_out
);

  localparam int unsigned CycW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CycW-1:0] CycLast = CycW'(CLKS_PER_BIT - 1);
  // Index of the last data bit: frame minus start and stop, minus one.
  localparam logic [2:0] BitLast = 3'(FrameBits - 3);

  tx_state_e          state_q;
  logic [CycW-1:0]    cyc_q;
  logic [2:0]         bit_q;
  logic [CwWidth-1:0] shift_q;
  logic [CwWidth-1:0] cw_q;
  logic               tx_q;
  logic               done_q;

  logic [CwWidth-1:0] enc_cw;
  logic               accept;
  logic               cyc_wrap;

  hamming74_encode u_encode (
    .data_in  (data_in),
    .err_pos  (err_pos),
    .codeword (enc_cw)
  );

  assign accept   = data_valid && data_ready;
  assign cyc_wrap = (cyc_q == CycLast);

  // FSM, counters, shift register and registered line/pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      cw_q    <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StStart;
            tx_q    <= 1'b0;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= enc_cw;
            cw_q    <= enc_cw;
          end
        end
        StStart: begin
          if (cyc_wrap) begin
            state_q <= StData;
            cyc_q   <= '0;
            tx_q    <= shift_q[0];
          end else begin
            cyc_q <= cyc_q + CycW'(1);
          end
        end
        StData: begin
          if (cyc_wrap) begin
            cyc_q <= '0;
            if (bit_q == BitLast) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
              // With one clock per bit the first stop cycle is also the last.
              done_q  <= (CycLast == '0);
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[CwWidth-1:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            cyc_q <= cyc_q + CycW'(1);
          end
        end
        StStop: begin
          if (cyc_wrap) begin
            state_q <= StIdle;
            cyc_q   <= '0;
          end else begin
            cyc_q  <= cyc_q + CycW'(1);
            // Raise the pulse so it is visible during the final stop cycle.
            done_q <= ((cyc_q + CycW'(1)) == CycLast);
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  // Handshake and status decode from the registered state.
  always_comb begin
    data_ready   = (state_q == StIdle) && !reset;
    tx_busy      = (state_q != StIdle);
    tx_out       = tx_q;
    frame_done   = done_q;
    codeword_out = cw_q;
  end

endmodule

// File: tb/tb_hamming74_serial_tx.sv
// Scoreboard bench for hamming74_serial_tx: driver pushes expected frames, monitor
// decodes the serial line and compares.
module tb_hamming74_serial_tx;

  localparam int CPB      = 4;
  localparam int FrameCyc = 9 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] data_in = '0;
  logic [2:0] err_pos = '0;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       tx_out;
  logic       tx_busy;
  logic       frame_done;
  logic [6:0] codeword_out;

  hamming74_serial_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .err_pos      (err_pos),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .tx_out       (tx_out),
    .tx_busy      (tx_busy),
    .frame_done   (frame_done),
    .codeword_out (codeword_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] cw;
    logic [3:0] data;
    logic [2:0] err;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   b2b_mode = 0;
  int   prev_done = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // XOR of the indices of all set positions: zero for a valid codeword,
  // otherwise the position of a single flipped bit.
  function automatic int syndrome(input logic [6:0] c);
    int s = 0;
    for (int p = 1; p <= 7; p++) if (c[p-1]) s = s ^ p;
    return s;
  endfunction

  // Reference encoder: the unique word with the data in positions 3,5,6,7 and zero syndrome.
  function automatic logic [6:0] ref_codeword(input logic [3:0] d, input logic [2:0] e);
    logic [6:0] cand;
    logic [6:0] cw = '0;
    for (int w = 0; w < 128; w++) begin
      cand = 7'(w);
      if ({cand[6], cand[5], cand[4], cand[2]} == d && syndrome(cand) == 0) cw = cand;
    end
    if (e != 3'd0) cw[int'(e) - 1] = ~cw[int'(e) - 1];
    return cw;
  endfunction

  task automatic push_expect(input logic [3:0] d, input logic [2:0] e);
    exp_t x;
    x.cw = ref_codeword(d, e);
    x.data = d;
    x.err = e;
    sb.push_back(x);
  endtask

  // Monitor: detects a start bit, samples each bit mid-cell, checks timing and decode.
  initial begin : monitor
    int         active;
    int         mc;
    int         k;
    int         s;
    logic       eb;
    logic [6:0] rx;
    exp_t       cur;
    active = 0;
    mc = 0;
    cur.cw = '0;
    cur.data = '0;
    cur.err = '0;
    rx = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 0;
        continue;
      end
      if (frame_done && !(active != 0 && mc == FrameCyc - 1)) check("frame_done_stray", frame_done, 0);
      if (active == 0 && tx_out == 1'b0) begin
        active = 1;
        mc = 0;
        rx = '0;
        if (sb.size() == 0) begin
          check("unexpected_frame", 1, 0);
          cur.cw = '0;
          cur.data = '0;
          cur.err = '0;
        end else begin
          cur = sb.pop_front();
        end
        if (b2b_mode != 0 && prev_done >= 0) check("b2b_gap", cyc - prev_done, 2);
      end
      if (active != 0) begin
        if (mc % CPB == CPB / 2) begin
          k = mc / CPB;
          eb = (k == 0) ? 1'b0 : (k == 8) ? 1'b1 : cur.cw[k-1];
          check($sformatf("line_bit%0d", k), tx_out, eb);
          if (k >= 1 && k <= 7) rx[k-1] = tx_out;
        end
        if (mc == 4 * CPB) begin
          check("busy_mid", tx_busy, 1);
          check("ready_mid", data_ready, 0);
          check("cw_out", codeword_out, cur.cw);
        end
        if (mc == FrameCyc - 1) begin
          check("frame_done_last", frame_done, 1);
          prev_done = cyc;
        end
        if (mc == FrameCyc) begin
          check("ready_after", data_ready, 1);
          check("busy_after", tx_busy, 0);
          s = syndrome(rx);
          check("loop_syndrome", s, cur.err);
          if (s != 0) rx[s-1] = ~rx[s-1];
          check("loop_data", {rx[6], rx[5], rx[4], rx[2]}, cur.data);
          active = 0;
        end
        mc++;
      end
    end
  end

  task automatic send(input logic [3:0] d, input logic [2:0] e);
    int n = 0;
    data_in = d;
    err_pos = e;
    data_valid = 1'b1;
    while (!data_ready && n < 4 * FrameCyc) begin
      @(negedge clk);
      n++;
    end
    if (!data_ready) check("send_timeout", 0, 1);
    else push_expect(d, e);
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(data_ready && !tx_busy) && n < 4 * FrameCyc) begin
      @(negedge clk);
      n++;
    end
    if (!(data_ready && !tx_busy)) check("idle_timeout", 0, 1);
  endtask

  // Hold data_valid high, changing data every cycle; only IDLE cycles accept.
  task automatic b2b(input int frames);
    int cnt = 0;
    int guard = 0;
    data_valid = 1'b1;
    while (cnt < frames && guard < frames * FrameCyc * 2) begin
      data_in = 4'($urandom);
      err_pos = 3'($urandom_range(0, 7));
      if (data_ready) begin
        push_expect(data_in, err_pos);
        cnt++;
      end
      @(negedge clk);
      guard++;
    end
    data_valid = 1'b0;
    if (cnt < frames) check("b2b_timeout", cnt, frames);
  endtask

  typedef struct {
    logic [3:0] d;
    logic [2:0] e;
    logic [6:0] cw;
  } dir_t;

  dir_t dir_tab[6] = '{
    '{4'b1011, 3'd0, 7'b1010101},
    '{4'b0000, 3'd0, 7'b0000000},
    '{4'b1111, 3'd0, 7'b1111111},
    '{4'b0001, 3'd0, 7'b0000111},
    '{4'b1011, 3'd3, 7'b1010001},
    '{4'b1011, 3'd7, 7'b0010101}
  };

  initial begin : driver
    int stray;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("ready_in_reset", data_ready, 0);
    check("tx_in_reset", tx_out, 1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_tx_out", tx_out, 1);
    check("rst_ready", data_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_cw", codeword_out, 0);
    check("rst_done", frame_done, 0);
    stray = 0;
    repeat (50) begin
      @(negedge clk);
      if (frame_done) stray++;
    end
    check("idle_no_done", stray, 0);

    foreach (dir_tab[i]) begin
      send(dir_tab[i].d, dir_tab[i].e);
      check($sformatf("cw_lit%0d", i), codeword_out, dir_tab[i].cw);
      wait_idle();
    end

    b2b_mode = 1;
    prev_done = -1;
    b2b(8);
    wait_idle();
    b2b_mode = 0;

    for (int i = 0; i < 10; i++) begin
      send(4'($urandom), 3'($urandom_range(0, 7)));
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Abort a frame during data bit 3, then send a clean frame afterwards.
    send(4'($urandom), 3'($urandom_range(0, 7)));
    repeat (4 * CPB + 1) @(negedge clk);
    check("abort_busy_before", tx_busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_tx_out", tx_out, 1);
    check("abort_busy", tx_busy, 0);
    check("abort_done", frame_done, 0);
    check("abort_cw", codeword_out, 0);
    check("abort_ready", data_ready, 0);
    sb.delete();
    reset = 1'b0;
    @(negedge clk);
    check("post_abort_ready", data_ready, 1);
    send(4'b0110, 3'd5);
    check("post_abort_cw", codeword_out, ref_codeword(4'b0110, 3'd5));
    wait_idle();

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
